// File: rtl/pingpong_ctrl.sv
// Bank ownership and write-pointer control for the ping-pong frame buffer.
// It tracks which bank is being filled, which bank is presented for reading, and the sticky overflow flag.
module pingpong_ctrl #(
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic                  rd_done,
    output logic                  wr_ready,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  rd_frame_valid,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [1:0] bank_full;
    logic [1:0] bank_full_next;
    logic       frame_done;
    logic       release_bank;

    assign wr_ready       = !bank_full[wr_bank];
    assign rd_frame_valid = bank_full[rd_bank];
    assign write_en       = wr_valid && wr_ready && !flush;
    assign frame_done     = write_en && (wr_ptr == LAST_ADDR);
    assign release_bank   = rd_done && rd_frame_valid;

    // Fill and release always hit different banks, because the write bank is never full.
    always_comb begin
        bank_full_next = bank_full;
        if (frame_done) begin
            bank_full_next[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            bank_full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            bank_full <= bank_full_next;
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (frame_done) begin
                wr_ptr  <= '0;
                wr_bank <= !wr_bank;
            end else if (write_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (release_bank) begin
                rd_bank <= !rd_bank;
            end
        end
    end

endmodule

// File: rtl/pingpong_buffer.sv
// Double-banked frame buffer: a producer streams into one bank while a consumer randomly reads the other completed bank.
// This module holds the storage array and the combinational read mux; pingpong_ctrl owns the bank bookkeeping.
module pingpong_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic                  rd_frame_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_done,
    output logic                  rd_bank,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];
    logic                  write_en;
    logic                  wr_bank;
    logic                  rd_in_range;

    pingpong_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wr_valid       (wr_valid),
        .rd_done        (rd_done),
        .wr_ready       (wr_ready),
        .write_en       (write_en),
        .wr_ptr         (wr_ptr),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .rd_frame_valid (rd_frame_valid),
        .overflow       (overflow)
    );

    // Memory is cleared only by rst; flush deliberately leaves stored words in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem[b][a] <= '0;
                end
            end
        end else if (write_en) begin
            mem[wr_bank][wr_ptr] <= wr_data;
        end
    end

    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;

    // Addresses past the end of a bank (non-power-of-2 DEPTH) read as zero.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: tb/tb_pingpong_buffer.sv
// Self-checking bench for pingpong_buffer with DEPTH=4: a frame-queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pingpong_buffer;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rd_frame_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_done;
    logic                  rd_bank;
    logic                  overflow;

    int errors = 0;
    int checks = 0;

    pingpong_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .wr_ptr         (wr_ptr),
        .rd_frame_valid (rd_frame_valid),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_done        (rd_done),
        .rd_bank        (rd_bank),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: completed frames waiting in order, the partial frame being built, and frame counters.
    logic [DEPTH*DATA_WIDTH-1:0] done_frames[$];
    logic [DATA_WIDTH-1:0]       partial[$];
    int                          frames_consumed;
    logic                        m_overflow;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            done_frames.delete();
            partial.delete();
            frames_consumed = 0;
            m_overflow = 1'b0;
        end else begin
            automatic bit ready = done_frames.size() < 2;
            automatic bit avail = done_frames.size() > 0;
            if (rd_done && avail) begin
                void'(done_frames.pop_front());
                frames_consumed++;
            end
            if (wr_valid && !ready) begin
                m_overflow = 1'b1;
            end else if (wr_valid) begin
                partial.push_back(wr_data);
                if (partial.size() == DEPTH) begin
                    automatic logic [DEPTH*DATA_WIDTH-1:0] f = '0;
                    for (int i = 0; i < DEPTH; i++) f[i*DATA_WIDTH +: DATA_WIDTH] = partial[i];
                    done_frames.push_back(f);
                    partial.delete();
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("m_wr_ready", 32'(wr_ready), 32'(done_frames.size() < 2));
            checkOutput("m_rd_frame_valid", 32'(rd_frame_valid), 32'(done_frames.size() > 0));
            checkOutput("m_rd_bank", 32'(rd_bank), 32'(frames_consumed % 2));
            checkOutput("m_wr_ptr", 32'(wr_ptr), 32'(partial.size()));
            checkOutput("m_overflow", 32'(overflow), 32'(m_overflow));
            if (done_frames.size() > 0)
                checkOutput("m_rd_data", 32'(rd_data),
                            32'(done_frames[0][int'(rd_addr)*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // Holds the given inputs across exactly one rising edge, returning 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [DATA_WIDTH-1:0] d, input logic done,
                                 input logic [ADDR_WIDTH-1:0] a, input logic fl);
        wr_valid = v;
        wr_data  = d;
        rd_done  = done;
        rd_addr  = a;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [ADDR_WIDTH-1:0] a);
        rd_addr = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_done = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);

        // Idle after reset
        checkOutput("rst_wr_ready", 32'(wr_ready), 1);
        checkOutput("rst_rd_frame_valid", 32'(rd_frame_valid), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_wr_ptr", 32'(wr_ptr), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);

        // First frame 1..4 into bank 0
        for (int w = 1; w <= 4; w++) applyStimulus(1, 16'(w), 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f0_rd_frame_valid", 32'(rd_frame_valid), 1);
        checkOutput("f0_rd_bank", 32'(rd_bank), 0);
        checkOutput("f0_wr_ptr", 32'(wr_ptr), 0);
        peek(2);
        checkOutput("f0_rd_data_a2", 32'(rd_data), 3);

        // Second frame 5..8 fills bank 1, then word 9 overflows
        for (int w = 5; w <= 8; w++) applyStimulus(1, 16'(w), 0, 0, 0);
        checkOutput("full_wr_ready", 32'(wr_ready), 0);
        applyStimulus(1, 9, 0, 0, 0);
        checkOutput("ovf_overflow", 32'(overflow), 1);
        peek(0);
        checkOutput("ovf_bank0_intact", 32'(rd_data), 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("rel_rd_bank", 32'(rd_bank), 1);
        checkOutput("rel_wr_ready", 32'(wr_ready), 1);
        peek(0);
        checkOutput("rel_rd_data_a0", 32'(rd_data), 5);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("rel2_rd_bank", 32'(rd_bank), 0);
        checkOutput("rel2_rd_frame_valid", 32'(rd_frame_valid), 0);

        // rd_done with nothing to read is ignored
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("ign_rd_bank", 32'(rd_bank), 0);
        checkOutput("ign_rd_frame_valid", 32'(rd_frame_valid), 0);
        checkOutput("ign_overflow_sticky", 32'(overflow), 1);

        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("flush_overflow", 32'(overflow), 0);

        // Stream 12 words, releasing the previous frame as each later frame completes
        for (int w = 1; w <= 12; w++) begin
            peek(ADDR_WIDTH'((w - 1) % DEPTH));
            checkOutput("strm_wr_ready", 32'(wr_ready), 1);
            if (w >= 5) checkOutput("strm_rd_data", 32'(rd_data), 32'(w - 4));
            applyStimulus(1, 16'(w), (w == 8 || w == 12), rd_addr, 0);
        end
        checkOutput("strm_rd_bank", 32'(rd_bank), 0);
        for (int a = 0; a < DEPTH; a++) begin
            peek(ADDR_WIDTH'(a));
            checkOutput("strm_f2_data", 32'(rd_data), 32'(9 + a));
        end
        applyStimulus(0, 0, 1, 0, 0);

        // Flush mid-frame
        applyStimulus(1, 13, 0, 0, 0);
        applyStimulus(1, 14, 0, 0, 0);
        checkOutput("pre_flush_wr_ptr", 32'(wr_ptr), 2);
        applyStimulus(1, 15, 0, 0, 1);
        checkOutput("flush_wr_ptr", 32'(wr_ptr), 0);
        checkOutput("flush_rd_frame_valid", 32'(rd_frame_valid), 0);
        for (int w = 21; w <= 24; w++) applyStimulus(1, 16'(w), 0, 0, 0);
        checkOutput("flush_rd_bank", 32'(rd_bank), 0);
        for (int a = 0; a < DEPTH; a++) begin
            peek(ADDR_WIDTH'(a));
            checkOutput("flush_frame_data", 32'(rd_data), 32'(21 + a));
        end
        applyStimulus(0, 0, 1, 0, 0);

        // Async reset mid-frame
        applyStimulus(1, 31, 0, 0, 0);
        applyStimulus(1, 32, 0, 0, 0);
        wr_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        checkOutput("arst_wr_ptr", 32'(wr_ptr), 0);
        checkOutput("arst_rd_frame_valid", 32'(rd_frame_valid), 0);
        checkOutput("arst_overflow", 32'(overflow), 0);
        @(posedge clk);
        #1;
        for (int w = 41; w <= 44; w++) applyStimulus(1, 16'(w), 0, 0, 0);
        checkOutput("arst_rd_frame_valid2", 32'(rd_frame_valid), 1);
        checkOutput("arst_rd_bank", 32'(rd_bank), 0);
        for (int a = 0; a < DEPTH; a++) begin
            peek(ADDR_WIDTH'(a));
            checkOutput("arst_frame_data", 32'(rd_data), 32'(41 + a));
        end
        applyStimulus(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
